// File: rtl/ariane_pkg.sv
// Core-wide types and widths used by the functional units.
//   csr_op_t  : CSR operation encoding (register and immediate forms)
//   fu_data_t : payload handed from issue to a functional unit
package ariane_pkg;

  localparam int unsigned XLEN           = riscv::XLEN;
  localparam int unsigned CSR_ADDR_WIDTH = 12;
  localparam int unsigned TRANS_ID_BITS  = 3;

  typedef enum logic [3:0] {
    CSR_READ,
    CSR_WRITE,
    CSR_SET,
    CSR_CLEAR,
    CSRRW,
    CSRRS,
    CSRRC,
    CSRRWI,
    CSRRSI,
    CSRRCI
  } csr_op_t;

  typedef struct packed {
    riscv::xlen_t              operand_a;
    riscv::xlen_t              operand_b;
    csr_op_t                   csr_op;
    logic [CSR_ADDR_WIDTH-1:0] csr_addr;
    logic [TRANS_ID_BITS-1:0]  trans_id;
  } fu_data_t;

endpackage

// File: rtl/riscv.sv
// Base ISA definitions shared by the core.
//   XLEN   : integer register / datapath width
//   xlen_t : one XLEN-wide datapath word
package riscv;

  localparam int unsigned XLEN = 64;

  typedef logic [XLEN-1:0] xlen_t;

endpackage

// File: rtl/csr_buffer.sv
// Single-entry holding buffer for CSR instructions between issue and commit.
// The CSR address is parked here until the commit stage retires the op, since
// CSR state may only change at commit. operand_a is returned unchanged as the
// writeback value.
//
// Ports:
//   clk_i        : clock, rising edge
//   rst_ni       : synchronous reset, active HIGH despite the name
//   flush_i      : drop any outstanding entry
//   fu_data_i    : issue payload
//   csr_ready_o  : buffer can take a CSR op this cycle
//   csr_valid_i  : issue presents a CSR op
//   csr_result_o : writeback value (fu_data_i.operand_a)
//   csr_commit_i : commit retires the buffered op
//   csr_addr_o   : address of the buffered op
module csr_buffer
  import ariane_pkg::*;
#(
  parameter int unsigned CSR_ADDR_WIDTH = ariane_pkg::CSR_ADDR_WIDTH,
  parameter int unsigned XLEN           = ariane_pkg::XLEN
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  fu_data_t                  fu_data_i,
  output logic                      csr_ready_o,
  input  logic                      csr_valid_i,
  output logic [XLEN-1:0]           csr_result_o,
  input  logic                      csr_commit_i,
  output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o
);

  logic                      valid_q, valid_d;
  logic [CSR_ADDR_WIDTH-1:0] addr_q, addr_d;

  // Only operand_a and csr_addr are consumed here.
  logic unused_fu_fields;
  assign unused_fu_fields = ^{fu_data_i.operand_b, fu_data_i.csr_op, fu_data_i.trans_id};

  assign csr_result_o = fu_data_i.operand_a;
  assign csr_addr_o   = addr_q;
  // A commit frees the slot in the same cycle, allowing back-to-back CSR ops.
  assign csr_ready_o  = ~valid_q | csr_commit_i;

  // Priority: flush, accept, commit-clear. Address holds unless a new op loads.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (csr_valid_i && csr_ready_o) begin
      valid_d = 1'b1;
      addr_d  = fu_data_i.csr_addr;
    end else if (csr_commit_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_csr_buffer.sv
// Directed self-checking bench for csr_buffer.
module tb_csr_buffer;
  import ariane_pkg::*;

  logic                clk;
  logic                rst_ni;
  logic                flush_i;
  fu_data_t            fu_data_i;
  logic                csr_ready_o;
  logic                csr_valid_i;
  logic [XLEN-1:0]     csr_result_o;
  logic                csr_commit_i;
  logic [CSR_ADDR_WIDTH-1:0] csr_addr_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  csr_buffer dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .fu_data_i    (fu_data_i),
    .csr_ready_o  (csr_ready_o),
    .csr_valid_i  (csr_valid_i),
    .csr_result_o (csr_result_o),
    .csr_commit_i (csr_commit_i),
    .csr_addr_o   (csr_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one rising edge; inputs change and outputs settle 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [63:0] a, input logic [63:0] b, input csr_op_t op,
                        input logic [11:0] addr);
    fu_data_i.operand_a = a;
    fu_data_i.operand_b = b;
    fu_data_i.csr_op    = op;
    fu_data_i.csr_addr  = addr;
    fu_data_i.trans_id  = 3'd1;
  endtask

  initial begin
    rst_ni       = 1'b1;
    flush_i      = 1'b0;
    csr_valid_i  = 1'b0;
    csr_commit_i = 1'b0;
    set_op(64'h5555, 64'h0, CSR_READ, 12'hfff);

    // Reset
    tick();
    rst_ni = 1'b0;
    #1;
    check("reset_ready", csr_ready_o, 1);
    check("reset_addr", csr_addr_o, 0);
    check("reset_result", csr_result_o, 64'h5555);

    // Issue
    set_op(64'd10, 64'd20, CSRRW, 12'd10);
    csr_valid_i = 1'b1;
    #1;
    check("issue_result_same_cycle", csr_result_o, 10);
    check("issue_ready_empty", csr_ready_o, 1);
    tick();
    csr_valid_i = 1'b0;
    #1;
    check("issue_addr", csr_addr_o, 10);
    check("issue_ready_full", csr_ready_o, 0);
    set_op(64'hdead_beef_0123_4567, 64'd0, CSR_SET, 12'h7ff);
    #1;
    check("result_ignores_valid", csr_result_o, 64'hdead_beef_0123_4567);
    check("addr_held_full", csr_addr_o, 10);

    // Commit
    csr_commit_i = 1'b1;
    #1;
    check("commit_ready_same_cycle", csr_ready_o, 1);
    tick();
    csr_commit_i = 1'b0;
    #1;
    check("commit_ready_after", csr_ready_o, 1);
    check("commit_addr_held", csr_addr_o, 10);

    // Commit while empty: no effect
    csr_commit_i = 1'b1;
    tick();
    csr_commit_i = 1'b0;
    #1;
    check("empty_commit_ready", csr_ready_o, 1);
    check("empty_commit_addr", csr_addr_o, 10);

    // Refill with 10, then back-to-back commit + issue 0x300
    set_op(64'd10, 64'd20, CSRRW, 12'd10);
    csr_valid_i = 1'b1;
    tick();
    check("refill_ready", csr_ready_o, 0);
    set_op(64'd1, 64'd2, CSRRS, 12'h300);
    csr_commit_i = 1'b1;
    #1;
    check("b2b_ready_same_cycle", csr_ready_o, 1);
    tick();
    csr_valid_i  = 1'b0;
    csr_commit_i = 1'b0;
    #1;
    check("b2b_ready", csr_ready_o, 0);
    check("b2b_addr", csr_addr_o, 12'h300);

    // Flush overrides a simultaneous issue
    set_op(64'd3, 64'd4, CSRRC, 12'h341);
    flush_i     = 1'b1;
    csr_valid_i = 1'b1;
    tick();
    flush_i     = 1'b0;
    csr_valid_i = 1'b0;
    #1;
    check("flush_ready", csr_ready_o, 1);
    check("flush_addr_held", csr_addr_o, 12'h300);

    // Refill 0x300, then blocked issue of 0x342
    set_op(64'd5, 64'd6, CSRRW, 12'h300);
    csr_valid_i = 1'b1;
    tick();
    set_op(64'd7, 64'd8, CSRRW, 12'h342);
    #1;
    check("blocked_ready", csr_ready_o, 0);
    tick();
    tick();
    csr_valid_i = 1'b0;
    #1;
    check("blocked_addr", csr_addr_o, 12'h300);
    check("blocked_still_full", csr_ready_o, 0);

    // Flush overrides a simultaneous commit + issue
    set_op(64'd9, 64'd9, CSRRW, 12'h123);
    flush_i      = 1'b1;
    csr_commit_i = 1'b1;
    csr_valid_i  = 1'b1;
    tick();
    flush_i      = 1'b0;
    csr_commit_i = 1'b0;
    csr_valid_i  = 1'b0;
    #1;
    check("flush_commit_ready", csr_ready_o, 1);
    check("flush_commit_addr", csr_addr_o, 12'h300);

    // Reset has priority over a pending issue
    set_op(64'd11, 64'd0, CSRRW, 12'h456);
    csr_valid_i = 1'b1;
    rst_ni      = 1'b1;
    tick();
    rst_ni      = 1'b0;
    csr_valid_i = 1'b0;
    #1;
    check("reset_prio_ready", csr_ready_o, 1);
    check("reset_prio_addr", csr_addr_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/csr_buffer.md
Name: csr_buffer

Overview:
- Single-entry holding buffer for CSR instructions between issue and commit.
- Accepts one CSR op from the issue stage and returns operand_a as the writeback result.
- Keeps the CSR address until commit, because CSRs may only change at commit. The commit stage reads csr_addr_o when it retires the instruction.
- Blocks further CSR issue while an entry is outstanding. A flush drops any outstanding entry.

Parameters:
- CSR_ADDR_WIDTH, 12, width of the CSR address field and of csr_addr_o.
- XLEN, 64, datapath width. Equals riscv::XLEN, so riscv::xlen_t is logic [XLEN-1:0].

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset. Synchronous and active-high: the port keeps the codebase name rst_ni, but rst_ni=1 at a rising edge resets.
- flush_i  in  1  synchronous flush; discards the stored entry.
- fu_data_i  in  fu_data_t  issue payload. Fields: operand_a (XLEN), operand_b (XLEN), csr_op (csr_op_t), csr_addr (CSR_ADDR_WIDTH), trans_id.
- csr_ready_o  out  1  buffer can accept a CSR op this cycle.
- csr_valid_i  in  1  issue presents a CSR op this cycle.
- csr_result_o  out  XLEN  writeback value.
- csr_commit_i  in  1  commit stage retires the buffered CSR op this cycle.
- csr_addr_o  out  CSR_ADDR_WIDTH  address of the buffered CSR op.

Behaviour:
- State: valid_q (1 bit) and addr_q (CSR_ADDR_WIDTH bits). Two logical states, EMPTY (valid_q=0) and FULL (valid_q=1).
- Reset (rst_ni=1 at an edge): valid_q=0, addr_q=0. After reset: csr_ready_o=1, csr_addr_o=0, csr_result_o=fu_data_i.operand_a. Reset has priority over flush, valid and commit.
- csr_result_o = fu_data_i.operand_a. Combinational, zero latency, independent of state and of csr_valid_i.
- csr_addr_o = addr_q (registered).
- csr_ready_o = ~valid_q | csr_commit_i. Combinational, so a commit frees the slot in the same cycle.
- Accept: csr_valid_i & csr_ready_o at an edge sets valid_q=1 and addr_q=fu_data_i.csr_addr. Visible on csr_addr_o from the next cycle.
- csr_valid_i while csr_ready_o=0 is ignored. addr_q is unchanged and no error is raised; issue must not do this.
- Commit with no new valid: valid_q becomes 0 at the edge. addr_q holds its value.
- Commit and valid in the same cycle: the old entry retires and the new one loads, so valid_q stays 1 and addr_q takes the new address.
- Commit while EMPTY: no effect.
- Flush: valid_q=0 at the edge and addr_q holds. Flush overrides a simultaneous accept and a simultaneous commit.
- Priority, highest first: reset, flush, accept, commit-clear.
- Transitions:
  - EMPTY to FULL on accept.
  - FULL to EMPTY on commit without accept, or on flush.
  - FULL to FULL on commit with accept.
- No other latency; there are no multi-cycle paths.

Decomposition:
- Shared package ariane_pkg holds:
  - csr_op_t enum, including CSR_READ, CSR_WRITE, CSR_SET, CSR_CLEAR, CSRRW, CSRRS, CSRRC and their immediate forms.
  - fu_data_t packed struct with fields operand_a, operand_b, csr_op, csr_addr, trans_id.
  - Width constants XLEN and CSR_ADDR_WIDTH=12.
- riscv package holds xlen_t.
- No sub-module; one flat module with one register process and combinational assigns.

Test Plan:
- Reset: rst_ni=1 for 1 cycle, then 0 -> csr_ready_o=1, csr_addr_o=0.
- Issue: fu_data_i={operand_a=10, operand_b=20, csr_op=CSRRW, csr_addr=10}, csr_valid_i=1 for 1 cycle ->
  - csr_result_o=10 in the same cycle;
  - next cycle csr_addr_o=10 and csr_ready_o=0.
- Commit: csr_commit_i=1 for 1 cycle while FULL -> csr_ready_o=1 in that cycle; next cycle valid_q=0, csr_ready_o=1, csr_addr_o still 10.
- Back-to-back: FULL with addr 10; assert csr_commit_i and csr_valid_i with csr_addr=0x300 together -> next cycle csr_ready_o=0 and csr_addr_o=0x300.
- Flush: FULL, then flush_i=1 for 1 cycle with csr_valid_i=1 and csr_addr=0x341 -> next cycle csr_ready_o=1 and csr_addr_o unchanged (0x300).
- Blocked issue: FULL with 0x300, csr_valid_i=1 with csr_addr=0x342 and no commit -> csr_ready_o=0 and csr_addr_o stays 0x300.
